// File: rtl/onehot_priority_decoder.sv
// Expands 8-bit priority-encoder codes (0x00-0x0F index, 0xF0 none) into 16-bit one-hot
// results through an input FIFO and a registered output stage; illegal codes are flagged.
//
// state | meaning
// EMPTY | output register holds nothing, out_valid=0
// HOLD  | output register presents a decoded result, out_valid=1
module onehot_priority_decoder #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_onehot,
  output logic             out_none,
  output logic             err_flag,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t           state;
  logic [4:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;
  logic [4:0]       head;

  assign legal     = (in_code[7:4] == 4'h0) || (in_code == 8'hF0);
  assign in_ready  = !rst && (level < DEPTH_L);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = (level != '0) && ((state == EMPTY) || out_ready);
  assign head      = mem[rd_ptr];
  assign out_valid = (state == HOLD);

  // Entries store {none, index}; bit 7 of a legal code is set only for 0xF0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_code[7], in_code[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_onehot <= '0;
      out_none   <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept && !legal) err_flag <= 1'b1;
      level <= level + LVL_W'(push) - LVL_W'(pop);

      if (pop) begin
        state <= HOLD;
        if (head[4]) begin
          out_onehot <= '0;
          out_none   <= 1'b1;
        end else begin
          out_onehot <= 16'h0001 << head[3:0];
          out_none   <= 1'b0;
        end
      end else if (state == HOLD && out_ready) begin
        state      <= EMPTY;
        out_onehot <= '0;
        out_none   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_priority_decoder.sv
// Bench for onehot_priority_decoder: queue scoreboard of expected results plus
// directed checks on reset, latency, error flag, backpressure, streaming and mid-run reset.
module tb_onehot_priority_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_code;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_onehot;
  logic        out_none;
  logic        err_flag;
  logic [2:0]  level;

  int n_cmp;
  int n_err;
  logic [16:0] exp_q[$];

  onehot_priority_decoder #(.DEPTH(4), .LVL_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_none   (out_none),
    .err_flag   (err_flag),
    .level      (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(input logic [7:0] code);
    if (code == 8'hF0) return {1'b1, 16'h0000};
    return {1'b0, 16'h0001 << code[3:0]};
  endfunction

  function automatic logic is_legal(input logic [7:0] code);
    return (code < 8'h10) || (code == 8'hF0);
  endfunction

  // Inputs change only at posedge+1, so values seen here are what the next edge consumes.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (in_valid && in_ready && is_legal(in_code)) exp_q.push_back(model(in_code));
      if (out_valid && out_ready) begin
        check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_val("sb_result", {15'd0, out_none, out_onehot}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [7:0] code;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_code = 8'h00;
    out_ready = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_err", 32'(err_flag), 32'd0);
    check_val("rst_onehot", 32'(out_onehot), 32'd0);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

    // single code, two-edge latency
    in_valid = 1'b1; in_code = 8'h05;
    tick();
    in_valid = 1'b0;
    check_val("lat_edge1_valid", 32'(out_valid), 32'd0);
    check_val("lat_edge1_level", 32'(level), 32'd1);
    tick();
    check_val("lat_edge2_valid", 32'(out_valid), 32'd1);
    check_val("single_onehot", 32'(out_onehot), 32'h0020);
    check_val("single_none", 32'(out_none), 32'd0);
    pulse_ready();
    check_val("drain_valid", 32'(out_valid), 32'd0);
    check_val("drain_onehot", 32'(out_onehot), 32'd0);

    // none code
    in_valid = 1'b1; in_code = 8'hF0;
    tick();
    in_valid = 1'b0;
    tick();
    check_val("none_onehot", 32'(out_onehot), 32'd0);
    check_val("none_flag", 32'(out_none), 32'd1);
    check_val("none_err", 32'(err_flag), 32'd0);
    pulse_ready();

    // illegal code then legal
    in_valid = 1'b1; in_code = 8'h10;
    tick();
    check_val("illegal_err", 32'(err_flag), 32'd1);
    check_val("illegal_level", 32'(level), 32'd0);
    in_code = 8'h0F;
    tick();
    in_valid = 1'b0;
    check_val("after_illegal_level", 32'(level), 32'd1);
    tick();
    check_val("after_illegal_valid", 32'(out_valid), 32'd1);
    check_val("after_illegal_onehot", 32'(out_onehot), 32'h8000);
    pulse_ready();
    check_val("illegal_one_result", 32'(out_valid), 32'd0);
    check_val("err_sticky", 32'(err_flag), 32'd1);

    // backpressure to full
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = 8'(i);
      tick();
    end
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    check_val("full_level", 32'(level), 32'd4);
    check_val("full_head", 32'(out_onehot), 32'h0001);
    in_code = 8'h05;
    tick();
    tick();
    check_val("refused_level", 32'(level), 32'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("first_pop_in_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 5; i++) begin
      check_val("burst_valid", 32'(out_valid), 32'd1);
      check_val("burst_onehot", 32'(out_onehot), 32'h0001 << i);
      tick();
    end
    check_val("burst_done", 32'(out_valid), 32'd0);

    // streaming with wrap
    for (int i = 0; i < 20; i++) begin
      code = 8'($urandom_range(0, 16));
      if (code == 8'd16) code = 8'hF0;
      in_valid = 1'b1; in_code = code;
      tick();
      check_val("stream_level", 32'(level <= 3'd1), 32'd1);
      if (i > 0) check_val("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check_val("stream_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // reset mid-operation
    in_valid = 1'b1; in_code = 8'h33;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_code = 8'(i + 8);
      tick();
    end
    in_valid = 1'b0;
    check_val("pre_rst_level", 32'(level), 32'd3);
    check_val("pre_rst_valid", 32'(out_valid), 32'd1);
    check_val("pre_rst_err", 32'(err_flag), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_level", 32'(level), 32'd0);
    check_val("mid_rst_err", 32'(err_flag), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("no_stale", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    check_val("sb_all_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
